// File: rtl/loader_pkg.sv
// Shared types and defaults for the serial instruction-memory loader.
// Holds the loader state encoding, the byte-index width and the default parameter values.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

   localparam int         IDX_W             = 2;   // selects one of four bytes per word
   localparam int         DEFAULT_MAX_WORDS = 64;
   localparam logic [7:0] DEFAULT_BASE_ADDR = 8'd0;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit instruction word.
// word is combinational and already contains the byte being accepted this cycle.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        accept,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      word_q, word_d;

   always_comb begin
      word = word_q;
      for (int k = 0; k < 4; k++) begin
         if (accept && (idx_q == IDX_W'(k))) word[8*k +: 8] = byte_in;
      end
      word_full = accept && (idx_q == '1);

      idx_d  = idx_q;
      word_d = word_q;
      if (clear) begin
         idx_d  = '0;
         word_d = '0;
      end else if (accept) begin
         idx_d  = idx_q + 1'b1;
         word_d = word;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a 16-bit word count then little-endian words over a byte stream,
// writes them to instruction memory and holds the core until the image is complete.
module imem_loader
   import loader_pkg::*;
#(
   parameter int         MAX_WORDS = DEFAULT_MAX_WORDS,
   parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [7:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic        byte_ready_q, byte_ready_d;
   logic        wr_en_q, wr_en_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        cpu_hold_q, cpu_hold_d;
   logic        load_done_q, load_done_d;
   logic        load_err_q, load_err_d;

   logic        accept;
   logic        asm_accept;
   logic        asm_clear;
   logic [31:0] asm_word;
   logic        asm_full;
   logic [15:0] len_word;

   assign accept     = byte_valid && byte_ready_q;
   assign asm_accept = accept && (state_q == DATA);
   assign len_word   = {byte_in, len_q[7:0]};

   word_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .accept    (asm_accept),
      .clear     (asm_clear),
      .byte_in   (byte_in),
      .word      (asm_word),
      .word_full (asm_full)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      asm_clear = 1'b0;

      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d   = LEN_LO;
               cnt_d     = '0;
               asm_clear = 1'b1;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d[7:0] = byte_in;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[15:8] = byte_in;
               state_d     = ((len_word == '0) || (len_word > MAX_N)) ? ERR : DATA;
            end
         end
         DATA: begin
            if (asm_full) begin
               state_d   = WRITE;
               wr_addr_d = BASE_ADDR + {cnt_q[5:0], 2'b00};
               wr_data_d = asm_word;
            end
         end
         WRITE: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = (cnt_d == len_q) ? DONE : DATA;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
      wr_en_d      = (state_d == WRITE);
      cpu_hold_d   = !((state_d == IDLE) || (state_d == DONE));
      load_done_d  = (state_d == DONE);
      load_err_d   = (state_d == ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         cpu_hold_q   <= 1'b0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         byte_ready_q <= byte_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         cpu_hold_q   <= cpu_hold_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign cpu_hold   = cpu_hold_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;

endmodule
